// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state codes, LFSR constants and lamp interval
// for the multi-player reaction timer.
package reaction_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t COUNTDOWN = 3'd1;
  localparam state_t HOLD      = 3'd2;
  localparam state_t MEASURE   = 3'd3;
  localparam state_t DONE      = 3'd4;

  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
  // x^7 + x^6 + 1 -> feedback from bits 6 and 5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;

  localparam int LAMP_TICKS = 500;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running divider, one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst_n (async, active-low), tick (1 ms pulse).
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: start-light countdown, random hold, lights-out,
// then per-player ms reaction capture with false-start, winner, best time.
// Ports: MAX10_CLK1_50, reset_n, start, react -> lights, busy, done,
//        times, false_start, winner, winner_valid, best_time.
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int TIME_W       = 14,
  parameter int TICK_DIV     = 50000,
  parameter int N_LIGHTS     = 10,
  parameter int MIN_DELAY_MS = 200,
  parameter int TIMEOUT_MS   = 5000
) (
  input  logic                          MAX10_CLK1_50,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [N_PLAYERS-1:0]          react,
  output logic [N_LIGHTS-1:0]           lights,
  output logic                          busy,
  output logic                          done,
  output logic [N_PLAYERS*TIME_W-1:0]   times,
  output logic [N_PLAYERS-1:0]          false_start,
  output logic [2:0]                    winner,
  output logic                          winner_valid,
  output logic [TIME_W-1:0]             best_time
);

  // one counter serves lamp interval, hold delay and measurement
  localparam int CNT_W = (TIME_W > 16) ? TIME_W : 16;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [TIME_W-1:0] T_MAX = '1;

  logic                 tick;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     delay;
  logic [LFSR_W-1:0]    lfsr;
  logic                 start_q;
  logic [N_PLAYERS-1:0] react_q;
  logic [N_PLAYERS-1:0] latched;

  logic                 start_edge;
  logic [N_PLAYERS-1:0] react_edge;
  logic                 st_idle;
  logic                 st_cd;
  logic                 st_hold;
  logic                 st_meas;
  logic                 st_done;

  logic [N_PLAYERS-1:0] cap;
  logic [N_PLAYERS-1:0] fs_set;
  logic [N_PLAYERS-1:0] valid_nxt;
  logic [N_PLAYERS*TIME_W-1:0] times_nxt;
  logic [N_LIGHTS-1:0]  lights_nxt;

  logic [2:0]           win_idx;
  logic                 win_ok;
  logic [TIME_W-1:0]    win_time;

  logic                 meas_exit;
  logic                 allfs_exit;
  logic                 go_done;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (MAX10_CLK1_50),
    .rst_n (reset_n),
    .tick  (tick)
  );

  assign start_edge = start & ~start_q;
  assign react_edge = react & ~react_q;

  assign st_idle = (state == IDLE);
  assign st_cd   = (state == COUNTDOWN);
  assign st_hold = (state == HOLD);
  assign st_meas = (state == MEASURE);
  assign st_done = (state == DONE);

  assign busy = st_cd | st_hold | st_meas;
  assign done = st_done;

  assign lights_nxt = N_LIGHTS'({lights, 1'b1});

  // edges before lights-out disqualify; edges after capture once
  always_comb begin
    cap    = '0;
    fs_set = '0;
    if (st_meas) begin
      cap = react_edge & ~latched & ~false_start;
    end
    if (st_cd || st_hold) begin
      fs_set = react_edge & ~false_start;
    end
  end

  always_comb begin
    times_nxt = times;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (cap[i]) begin
        times_nxt[i*TIME_W +: TIME_W] = cnt[TIME_W-1:0];
      end else if (fs_set[i]) begin
        times_nxt[i*TIME_W +: TIME_W] = T_MAX;
      end
    end
  end

  assign valid_nxt = latched | cap;

  // strict less-than keeps the lowest index on a tie
  always_comb begin
    win_idx  = '0;
    win_ok   = 1'b0;
    win_time = T_MAX;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (valid_nxt[i] &&
          (!win_ok || times_nxt[i*TIME_W +: TIME_W] < win_time)) begin
        win_ok   = 1'b1;
        win_idx  = 3'(i);
        win_time = times_nxt[i*TIME_W +: TIME_W];
      end
    end
  end

  assign meas_exit = st_meas &&
    ((&(latched | cap | false_start)) ||
     (cnt == CNT_W'(TIMEOUT_MS)));

  assign allfs_exit = (st_cd || st_hold) && tick && (&false_start);

  assign go_done = meas_exit | allfs_exit;

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lights       <= '0;
      cnt          <= '0;
      delay        <= '0;
      lfsr         <= LFSR_SEED;
      start_q      <= 1'b0;
      react_q      <= '0;
      latched      <= '0;
      times        <= '1;
      false_start  <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      best_time    <= '1;
    end else begin
      start_q     <= start;
      react_q     <= react;
      times       <= times_nxt;
      false_start <= false_start | fs_set;
      latched     <= latched | cap;
      if (tick) begin
        lfsr <= lfsr_next(lfsr);
      end
      if (go_done) begin
        state        <= DONE;
        lights       <= '0;
        winner       <= win_idx;
        winner_valid <= win_ok;
        if (win_ok && (win_time < best_time)) begin
          best_time <= win_time;
        end
      end else begin
        unique case (1'b1)
          st_idle, st_done: begin
            if (start_edge) begin
              state        <= COUNTDOWN;
              cnt          <= '0;
              lights       <= '0;
              times        <= '1;
              false_start  <= '0;
              latched      <= '0;
              winner_valid <= 1'b0;
            end
          end
          st_cd: begin
            if (tick) begin
              if (cnt == CNT_W'(LAMP_TICKS - 1)) begin
                cnt    <= '0;
                lights <= lights_nxt;
                if (&lights_nxt) begin
                  state <= HOLD;
                  delay <= CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr);
                end
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
          st_hold: begin
            if (tick) begin
              // lights-out lands exactly on the delay-th tick
              if (cnt + ONE == delay) begin
                state  <= MEASURE;
                cnt    <= '0;
                lights <= '0;
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
          st_meas: begin
            if (tick) begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/reaction_timer_multi.md
# reaction_timer_multi

Parameterised multi-player reaction-timer core: a start-light countdown, then a pseudo-random hold, then lights-out. It measures each player's response in milliseconds, flags false starts, picks a winner and keeps a best-time record. It sits between the debounced key/GPIO inputs and the binary-to-BCD/7-segment display path. It replaces the fixed single-channel FSM/LFSR/DELAY arrangement with one self-contained, width- and player-scalable block.

## Interface
Parameters:
- N_PLAYERS, 2: number of react channels (1..8).
- TIME_W, 14: width of time results in ms; saturating value 2^TIME_W-1 means timeout/invalid.
- TICK_DIV, 50000: clock cycles per 1 ms tick (50 MHz board clock).
- N_LIGHTS, 10: countdown lights, lit one every 500 ms.
- MIN_DELAY_MS, 200: fixed part of the random hold.
- TIMEOUT_MS, 5000: measurement abort limit (< 2^TIME_W-1).

Ports:
- MAX10_CLK1_50  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous level; rising edge starts a round.
- react  in  N_PLAYERS  synchronised, active-high player buttons; rising edge counts.
- lights  out  N_LIGHTS  countdown lamp pattern.
- busy  out  1  high from accepted start until done.
- done  out  1  high in DONE state; results valid.
- times  out  N_PLAYERS*TIME_W  per-player result, player i at [i*TIME_W +: TIME_W].
- false_start  out  N_PLAYERS  player pressed before lights-out.
- winner  out  3  index of fastest valid player.
- winner_valid  out  1  at least one valid time.
- best_time  out  TIME_W  best winning time since reset.

## Operation
- Reset values: state IDLE, lights 0, busy 0, done 0, times all-ones, false_start 0, winner 0, winner_valid 0, best_time all-ones, LFSR 7'h01, tick divider 0.
- ms tick: a one-cycle pulse every TICK_DIV clocks. It is free-running.
- LFSR: 7-bit, polynomial x^7+x^6+1, advances on every ms tick in all states. It never holds zero.
- States:
  - IDLE: waits for a start edge. On the edge, clears times, false_start and winner_valid, then goes to COUNTDOWN.
  - COUNTDOWN: lights one more LSB-first lamp every 500 ticks. After N_LIGHTS lamps, goes to HOLD.
  - HOLD: latches delay = MIN_DELAY_MS + LFSR value on entry. Counts ticks. When the count reaches delay, clears lights and the ms counter, then goes to MEASURE.
  - MEASURE: the ms counter increments per tick. A react edge from a player that has not yet latched and is not false-started captures the current counter into times[i].
  - DONE: results hold until the next start edge, which behaves as it does from IDLE.
- A react edge in COUNTDOWN or HOLD sets false_start[i] and forces times[i] to all-ones. That player is ignored for the rest of the round.
- Exit from MEASURE to DONE happens when every non-false-started player has latched, or when the counter equals TIMEOUT_MS. Unlatched players keep all-ones.
- If every player false-starts, the round skips the rest of HOLD/MEASURE and goes to DONE at the next tick.
- Winner: the minimum latched time among valid players. On a tie, the lowest index wins. winner_valid is 0 if no valid time.
- Best time: updates to the winning time on entry to DONE if that time is strictly smaller. It survives rounds and clears only on reset.
- start edges outside IDLE/DONE are ignored. A react level that is already high at round start does not count; only rising edges count.

## Timing
- Edge detect: 1-register history per input. An edge is acted on in the cycle after the input rises.
- Captured time: the counter value in the cycle the edge is processed, in whole ms (0 = within the first ms after lights-out).
- Simultaneous react edges in one cycle: all are captured with equal times.
- A react edge in the same cycle as the HOLD→MEASURE transition counts as a false start.
- winner, winner_valid and best_time are registered. They are valid in the first cycle done = 1.
- Asynchronous reset mid-round returns everything to reset values immediately.

## Structure
- Shared package `reaction_pkg`: state enum (IDLE, COUNTDOWN, HOLD, MEASURE, DONE), LFSR taps/seed constants, the 500-tick lamp interval.
- Sub-module `ms_tick_gen` (TICK_DIV counter producing the 1 ms pulse). The LFSR and the winner comparator stay inline.

## Test plan
Run all scenarios with TICK_DIV=4, N_PLAYERS=2 and LFSR forced observable.
- Normal round: start, P0 reacts 120 ms and P1 180 ms after lights-out → times 120/180, winner 0, best_time 120.
- False start: P1 presses during COUNTDOWN, P0 presses at 250 ms → false_start=2'b10, times[1]=16383, winner 0.
- All false: both press in HOLD → DONE at next tick, winner_valid 0, best_time unchanged.
- Timeout: no presses → done after 5000 ms, both times 16383, winner_valid 0.
- Tie plus best-time hold: both press the same cycle at 300 ms → winner 0. A subsequent round at 400 ms leaves best_time 120.
- Reset mid-MEASURE: assert reset_n low → all outputs at reset values next edge, LFSR 7'h01.
